// File: rtl/instr_fetch_queue.sv
// Program buffer and fetch sequencer feeding control_unit.
// LOAD: button-keyed instructions are appended to a small memory.
// RUN: words are presented in order over a valid/ready handshake.
// HALT: parked after the last word unless loop mode wraps to pc 0.
module instr_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wr_req,
    input  logic [IW-1:0] wr_data,
    input  logic          run_req,
    input  logic          clear,
    input  logic          loop,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   prog_len,
    output logic          full,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_e;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          full_q, full_d;
    logic          wr_prev_q, run_prev_q;
    logic          wr_edge, run_edge;
    logic          mem_we;
    logic [IW-1:0] mem_q [DEPTH];

    assign wr_edge  = wr_req  & ~wr_prev_q;
    assign run_edge = run_req & ~run_prev_q;

    // Next-state: clear dominates; in LOAD a write and a run edge may both apply.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        mem_we  = 1'b0;
        if (clear) begin
            state_d = S_LOAD;
            pc_d    = '0;
            len_d   = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (wr_edge && !full_q) begin
                        mem_we = 1'b1;
                        len_d  = len_q + (AW+1)'(1);
                    end
                    // Run sees the length including a word written this same cycle.
                    if (run_edge && (len_d != '0)) begin
                        state_d = S_RUN;
                        pc_d    = '0;
                    end
                end
                S_RUN: begin
                    if (run_edge) begin
                        pc_d = '0;
                    end else if (instr_ready) begin
                        if (({1'b0, pc_q} + (AW+1)'(1)) < len_q)
                            pc_d = pc_q + AW'(1);
                        else if (loop)
                            pc_d = '0;
                        else
                            state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    if (run_edge) begin
                        state_d = S_RUN;
                        pc_d    = '0;
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
        full_d = (len_d == DEPTH_L);
    end

    // Control registers; button history resets high so a held button does not fire.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_LOAD;
            pc_q       <= '0;
            len_q      <= '0;
            full_q     <= 1'b0;
            wr_prev_q  <= 1'b1;
            run_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            full_q     <= full_d;
            wr_prev_q  <= wr_req;
            run_prev_q <= run_req;
        end
    end

    // Program memory: not reset, contents survive until overwritten.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[len_q[AW-1:0]] <= wr_data;
    end

    assign instr_valid = (state_q == S_RUN);
    assign instr       = instr_valid ? mem_q[pc_q] : '0;
    assign pc          = pc_q;
    assign prog_len    = len_q;
    assign full        = full_q;
    assign state       = state_q;

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Program buffer and fetch sequencer directly upstream of control_unit; replaces hand-keyed switch instructions. In LOAD, the user keys 8-bit instructions (format: [7] mode, [6:4] opcode, [3:2] regA, [1:0] regB) into a small memory. In RUN, it presents them in order to control_unit over a valid/ready handshake, where ready is control_unit's Fetch state. It then halts, or loops when loop mode is set.

Parameters:
DEPTH, 16, number of instruction words; power of two, at least 2
AW, 4, pointer width; must equal log2(DEPTH)
IW, 8, instruction width

Ports:
clock  in  1  system clock, rising edge active
resetn  in  1  asynchronous active-low reset
wr_req  in  1  level from push button; a 0->1 edge writes one word
wr_data  in  IW  instruction to write (from SW[7:0])
run_req  in  1  level from push button; a 0->1 edge starts or restarts execution
clear  in  1  synchronous level clear; returns to LOAD and empties the program
loop  in  1  1 = wrap to pc 0 after last instruction instead of halting
instr_ready  in  1  control_unit is in Fetch and samples instr this cycle
instr  out  IW  current instruction mem[pc]; 0 when instr_valid=0
instr_valid  out  1  instr is valid (RUN state only)
pc  out  AW  index of current instruction
prog_len  out  AW+1  number of words loaded (0..DEPTH)
full  out  1  prog_len == DEPTH
state  out  2  01 LOAD, 10 RUN, 11 HALT

Behaviour:
- Async reset (resetn=0):
  - state=LOAD, pc=0, prog_len=0, full=0, instr_valid=0, instr=0.
  - Edge-detect history registers are set to 1, so a button already held at reset release does not fire.
  - Memory contents are not reset.
- Edge detect:
  - Registered previous value per button.
  - An edge is detected in the cycle where req=1 and prev=0.
  - Acted on at the same clock edge. A held button produces exactly one action.
- Priority, per clock: clear > run edge > write edge.
  - Exception: in LOAD, a simultaneous write edge and run edge both apply. The word is written, then RUN is entered, with prog_len including the new word.
- LOAD:
  - Write edge with full=0: mem[prog_len]<=wr_data, prog_len++, full recomputed.
  - Write edge with full=1: ignored, no wrap.
  - Run edge with prog_len>0 (after any same-cycle write): state<=RUN, pc<=0.
  - Run edge with prog_len=0: ignored.
- RUN:
  - instr_valid=1.
  - instr=mem[pc], combinational read (distributed memory), 0-cycle latency from pc.
  - Transfer occurs when instr_valid&&instr_ready at the rising edge.
    - If pc<prog_len-1: pc++.
    - Else if loop=1: pc<=0.
    - Else: state<=HALT, pc unchanged.
  - No transfer means pc and instr are held stable.
  - Write edges are ignored. A run edge restarts: pc<=0, no transfer counted that cycle.
- HALT:
  - instr_valid=0, instr=0, pc holds the last index.
  - Run edge: state<=RUN, pc<=0 (rerun the same program).
  - Write edges are ignored.
- clear=1, any state: state<=LOAD, pc<=0, prog_len<=0, full<=0; the button history still updates.
- loop changing mid-RUN takes effect at the next last-word transfer.
- instr_ready while not RUN has no effect.
- Reset mid-operation: immediate return to reset values, no partial transfer. The program must be reloaded logically: prog_len=0 even though memory retains data.

Test Plan:
- Reset, with wr_req=run_req=1 held through release -> state=01, prog_len=0, instr_valid=0, instr=0. No write on release; a write occurs only after the button drops and rises again.
- Three write pulses with wr_data 0x30, 0x30, 0x10, each held 5 cycles -> prog_len=3, exactly 3 writes, full=0.
- Run pulse, instr_ready tied 1, loop=0:
  - Same cycle after the edge: instr_valid=1, instr=0x30, pc=0.
  - Next cycles: 0x30 (pc 1), 0x10 (pc 2).
  - Then state=11, instr_valid=0, pc=2.
- instr_ready pulsed once every 4 cycles (FDEW cadence) -> each instruction held 4 cycles, pc advances only on ready cycles.
- loop=1 with same program and ready=1 -> 0x30, 0x30, 0x10, 0x30, ... with no HALT. Clear mid-RUN -> state=01, prog_len=0 the next cycle.
- Write 16 words 0x00..0x0F -> full=1, prog_len=16. A 17th write is ignored; a run then yields word 0x0F at pc=15. Assert resetn=0 mid-RUN -> outputs are at reset values immediately.
